reg_file_alu: RTL and testbench

//   Datapath core: a 16 x 16-bit register file tightly coupled to a 16-bit ALU.
//   A is always register Rdest. B is register Rsrc or a 16-bit immediate.
//   The ALU result is written back to Rdest on the clock edge when enabled.

---
 rtl/reg_file_alu.sv | 113 +++++++++++
 tb/tb_reg_file_alu.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/reg_file_alu.sv
// reg_file_alu: 16 x 16-bit register file coupled to a 16-bit ALU.
// Operand A is always reg[RdestRegLoc]; operand B is Imm or reg[RsrcRegLoc].
// The ALU result is written back to reg[RdestRegLoc] on the rising clock edge.
module reg_file_alu (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        En,
    input  logic [3:0]  RdestRegLoc,
    input  logic [3:0]  RsrcRegLoc,
    input  logic [15:0] Imm,
    input  logic        Imm_s,
    input  logic [4:0]  OpCode,
    output logic [15:0] AluOutput,
    output logic [15:0] RdestOut,
    output logic [15:0] RsrcOut,
    output logic [15:0] AluSrcIn,
    output logic [4:0]  Flags
);

    localparam logic [4:0] opAdd  = 5'd0;
    localparam logic [4:0] opSub  = 5'd1;
    localparam logic [4:0] opCmp  = 5'd2;
    localparam logic [4:0] opAnd  = 5'd3;
    localparam logic [4:0] opOr   = 5'd4;
    localparam logic [4:0] opXor  = 5'd5;
    localparam logic [4:0] opNot  = 5'd6;
    localparam logic [4:0] opLsh  = 5'd7;
    localparam logic [4:0] opRsh  = 5'd8;
    localparam logic [4:0] opArsh = 5'd9;

    logic [15:0] regFile [16];
    logic [15:0] opA;
    logic [15:0] opB;
    logic [16:0] sumWide;
    logic [16:0] diffWide;
    logic [15:0] aluResult;
    logic        flagC;
    logic        flagL;
    logic        flagF;
    logic        flagZ;
    logic        flagN;
    logic        writeOk;

    // Combinational register reads and operand selection.
    assign RdestOut = regFile[RdestRegLoc];
    assign RsrcOut  = regFile[RsrcRegLoc];
    assign opA      = RdestOut;
    assign opB      = Imm_s ? Imm : RsrcOut;
    assign AluSrcIn = opB;

    // 17-bit forms expose carry out (ADD) and borrow (SUB) in bit 16.
    assign sumWide  = {1'b0, opA} + {1'b0, opB};
    assign diffWide = {1'b0, opA} - {1'b0, opB};

    // ALU result and flags for the current opcode.
    always_comb begin
        aluResult = '0;
        flagC     = 1'b0;
        flagL     = 1'b0;
        flagF     = 1'b0;
        flagZ     = 1'b0;
        flagN     = 1'b0;
        writeOk   = 1'b1;
        case (OpCode)
            opAdd: begin
                aluResult = sumWide[15:0];
                flagC     = sumWide[16];
                flagF     = (opA[15] == opB[15]) && (aluResult[15] != opA[15]);
            end
            opSub: begin
                aluResult = diffWide[15:0];
                flagC     = diffWide[16];
                flagF     = (opA[15] != opB[15]) && (aluResult[15] != opA[15]);
            end
            opCmp: begin
                aluResult = opA;
                writeOk   = 1'b0;
            end
            opAnd:  aluResult = opA & opB;
            opOr:   aluResult = opA | opB;
            opXor:  aluResult = opA ^ opB;
            opNot:  aluResult = ~opB;
            opLsh:  aluResult = opA << opB[3:0];
            opRsh:  aluResult = opA >> opB[3:0];
            opArsh: aluResult = $signed(opA) >>> opB[3:0];
            default: writeOk = 1'b0;
        endcase

        if (OpCode == opCmp) begin
            flagL = opA < opB;
            flagN = $signed(opA) < $signed(opB);
            flagZ = opA == opB;
        end else if (writeOk) begin
            flagN = aluResult[15];
            flagZ = aluResult == 16'h0000;
        end
    end

    assign AluOutput = aluResult;
    assign Flags     = {flagC, flagL, flagF, flagZ, flagN};

    // Register array: async clear, write-back of ALU result when enabled.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            for (int i = 0; i < 16; i++) begin
                regFile[i] <= '0;
            end
        end else if (En && writeOk) begin
            regFile[RdestRegLoc] <= aluResult;
        end
    end

endmodule

// File: tb/tb_reg_file_alu.sv
// Directed self-checking bench for reg_file_alu.
module tb_reg_file_alu;

    logic        Clk;
    logic        Rst;
    logic        En;
    logic [3:0]  RdestRegLoc;
    logic [3:0]  RsrcRegLoc;
    logic [15:0] Imm;
    logic        Imm_s;
    logic [4:0]  OpCode;
    logic [15:0] AluOutput;
    logic [15:0] RdestOut;
    logic [15:0] RsrcOut;
    logic [15:0] AluSrcIn;
    logic [4:0]  Flags;

    int checkCount = 0;
    int errorCount = 0;

    // Flags bit order {C,L,F,Z,N}
    localparam logic [4:0] fC = 5'b10000;
    localparam logic [4:0] fL = 5'b01000;
    localparam logic [4:0] fF = 5'b00100;
    localparam logic [4:0] fZ = 5'b00010;
    localparam logic [4:0] fN = 5'b00001;

    reg_file_alu dut (
        .Clk(Clk),
        .Rst(Rst),
        .En(En),
        .RdestRegLoc(RdestRegLoc),
        .RsrcRegLoc(RsrcRegLoc),
        .Imm(Imm),
        .Imm_s(Imm_s),
        .OpCode(OpCode),
        .AluOutput(AluOutput),
        .RdestOut(RdestOut),
        .RsrcOut(RsrcOut),
        .AluSrcIn(AluSrcIn),
        .Flags(Flags)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checkCount++;
        if (got !== exp) begin
            errorCount++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Drive an operation combinationally, with write enable off.
    task automatic setOp(input logic [3:0] rd, input logic [3:0] rs, input logic immS,
                         input logic [15:0] imm, input logic [4:0] op);
        En          = 1'b0;
        RdestRegLoc = rd;
        RsrcRegLoc  = rs;
        Imm_s       = immS;
        Imm         = imm;
        OpCode      = op;
        #1;
    endtask

    // Pulse En across exactly one rising edge, then settle.
    task automatic pulseWrite();
        En = 1'b1;
        @(posedge Clk);
        #1;
        En = 1'b0;
        #1;
    endtask

    initial begin
        Rst = 1'b0;
        setOp(4'd0, 4'd7, 1'b0, 16'h0000, 5'd0);
        @(posedge Clk);
        #2;
        check("reset_rdest", RdestOut, 16'h0000);
        check("reset_rsrc", RsrcOut, 16'h0000);
        check("reset_zflag", {11'd0, Flags}, {11'd0, fZ});
        Rst = 1'b1;
        @(posedge Clk);
        #1;

        // 1: r0 = 0 + 1
        setOp(4'd0, 4'd0, 1'b1, 16'h0001, 5'd0);
        check("t1_aluout", AluOutput, 16'h0001);
        check("t1_srcin", AluSrcIn, 16'h0001);
        pulseWrite();
        check("t1_r0", RdestOut, 16'h0001);
        check("t1_flags", {11'd0, Flags}, 16'h0000);

        // 2: ri = ri(0) + r0(1)
        for (int i = 1; i < 16; i++) begin
            setOp(4'(i), 4'd0, 1'b0, 16'hDEAD, 5'd0);
            check("t2_srcin", AluSrcIn, 16'h0001);
            pulseWrite();
            check($sformatf("t2_r%0d", i), RdestOut, 16'h0001);
        end

        // 3: overflow into sign, then borrow
        setOp(4'd1, 4'd0, 1'b1, 16'h7FFE, 5'd0);
        pulseWrite();
        check("t3_r1", RdestOut, 16'h7FFF);
        setOp(4'd1, 4'd0, 1'b1, 16'h0001, 5'd0);
        check("t3_add_out", AluOutput, 16'h8000);
        check("t3_add_flags", {11'd0, Flags}, {11'd0, fF | fN});
        @(posedge Clk);
        #1;
        check("t3_no_write_en0", RdestOut, 16'h7FFF);
        setOp(4'd2, 4'd0, 1'b1, 16'h0001, 5'd1);
        check("t3_sub_zero_flags", {11'd0, Flags}, {11'd0, fZ});
        pulseWrite();
        check("t3_r2", RdestOut, 16'h0000);
        check("t3_sub_out", AluOutput, 16'hFFFF);
        check("t3_sub_flags", {11'd0, Flags}, {11'd0, fC | fN});

        // 4: compares
        setOp(4'd3, 4'd0, 1'b1, 16'h0004, 5'd0);
        pulseWrite();
        setOp(4'd3, 4'd0, 1'b1, 16'h0005, 5'd2);
        check("t4_cmp_out", AluOutput, 16'h0005);
        check("t4_cmp_eq_flags", {11'd0, Flags}, {11'd0, fZ});
        pulseWrite();
        check("t4_cmp_no_write", RdestOut, 16'h0005);
        setOp(4'd3, 4'd0, 1'b1, 16'h0009, 5'd2);
        check("t4_cmp_lt_flags", {11'd0, Flags}, {11'd0, fL | fN});
        setOp(4'd4, 4'd0, 1'b1, 16'h7FFF, 5'd0);
        pulseWrite();
        check("t4_r4", RdestOut, 16'h8000);
        setOp(4'd4, 4'd0, 1'b1, 16'h0001, 5'd2);
        check("t4_cmp_signed_flags", {11'd0, Flags}, {11'd0, fN});

        // 5: shifts and logic on r5 = 0x8001
        setOp(4'd5, 4'd0, 1'b1, 16'h8000, 5'd0);
        pulseWrite();
        check("t5_r5", RdestOut, 16'h8001);
        setOp(4'd5, 4'd0, 1'b1, 16'h0001, 5'd7);
        check("t5_lsh", AluOutput, 16'h0002);
        check("t5_lsh_flags", {11'd0, Flags}, 16'h0000);
        setOp(4'd5, 4'd0, 1'b1, 16'h0001, 5'd8);
        check("t5_rsh", AluOutput, 16'h4000);
        setOp(4'd5, 4'd0, 1'b1, 16'h0001, 5'd9);
        check("t5_arsh", AluOutput, 16'hC000);
        check("t5_arsh_flags", {11'd0, Flags}, {11'd0, fN});
        setOp(4'd5, 4'd0, 1'b1, 16'h0011, 5'd7);
        check("t5_lsh_masked", AluOutput, 16'h0002);
        setOp(4'd5, 4'd0, 1'b1, 16'h00FF, 5'd6);
        check("t5_not", AluOutput, 16'hFF00);
        setOp(4'd5, 4'd0, 1'b1, 16'h00FF, 5'd3);
        check("t5_and", AluOutput, 16'h0001);
        setOp(4'd5, 4'd0, 1'b1, 16'h00FF, 5'd4);
        check("t5_or", AluOutput, 16'h80FF);
        setOp(4'd5, 4'd0, 1'b1, 16'h00FF, 5'd5);
        check("t5_xor", AluOutput, 16'h80FE);
        setOp(4'd5, 4'd5, 1'b0, 16'h0000, 5'd0);
        check("t5_self_add", AluOutput, 16'h0002);
        check("t5_self_add_flags", {11'd0, Flags}, {11'd0, fC | fF});
        setOp(4'd5, 4'd0, 1'b1, 16'h00FF, 5'd10);
        check("t5_undef_out", AluOutput, 16'h0000);
        check("t5_undef_flags", {11'd0, Flags}, 16'h0000);
        pulseWrite();
        check("t5_undef_no_write", RdestOut, 16'h8001);
        setOp(4'd5, 4'd0, 1'b1, 16'h00FF, 5'd31);
        pulseWrite();
        check("t5_op31_no_write", RdestOut, 16'h8001);

        // 6: async reset between edges overrides a pending write
        setOp(4'd3, 4'd5, 1'b1, 16'h0001, 5'd0);
        En = 1'b1;
        @(negedge Clk);
        Rst = 1'b0;
        #1;
        check("t6_rdest_async", RdestOut, 16'h0000);
        check("t6_rsrc_async", RsrcOut, 16'h0000);
        @(posedge Clk);
        #1;
        check("t6_no_write_in_reset", RdestOut, 16'h0000);
        En = 1'b0;
        @(negedge Clk);
        Rst = 1'b1;
        #1;
        check("t6_after_release", RdestOut, 16'h0000);
        RdestRegLoc = 4'd0;
        #1;
        check("t6_r0_cleared", RdestOut, 16'h0000);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
